// File: rtl/spi_master.sv
// spi_master: SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first.
// One DATA_W-bit frame is exchanged per accepted request. sclk is a
// registered divide of clk; each sclk half-period lasts CLK_DIV clk cycles.
//
// Ports:
//   clk       system clock
//   rst_L     asynchronous active-low reset
//   tx_data   frame to transmit, captured when tx_valid && tx_ready
//   tx_valid  request to start a frame
//   tx_ready  idle and able to accept a request
//   rx_data   last received frame, held until the next frame completes
//   rx_valid  one-cycle pulse when rx_data updates
//   sclk      SPI clock, idle low
//   cs_L      active-low chip select
//   mosi      serial data out
//   miso      serial data in
module spi_master #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              sclk,
  output logic              cs_L,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("spi_master: CLK_DIV must be 2 or more");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t            state;
  state_t            state_next;
  logic [DIV_W-1:0]  div;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic              tick;
  logic              accept;
  logic              last_fall;

  assign tick      = (div == DIV_W'(CLK_DIV - 1));
  assign tx_ready  = (state == IDLE);
  assign accept    = tx_valid && tx_ready;
  // Falling edge that completes the final bit of the frame.
  assign last_fall = (state == XFER) && tick && sclk &&
                     (bit_cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)    state_next = SETUP;
      SETUP:   if (tick)      state_next = XFER;
      XFER:    if (last_fall) state_next = HOLD;
      HOLD:    if (tick)      state_next = GAP;
      GAP:     if (tick)      state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      div      <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      sclk     <= 1'b0;
      cs_L     <= 1'b1;
      mosi     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      // Divider only runs while a frame (including its gap) is in progress.
      if (state == IDLE || tick) begin
        div <= '0;
      end else begin
        div <= div + DIV_W'(1);
      end

      case (state)
        IDLE: begin
          if (accept) begin
            tx_sh   <= tx_data;
            bit_cnt <= '0;
            cs_L    <= 1'b0;
            mosi    <= tx_data[DATA_W-1];
          end
        end
        SETUP: begin
          if (tick) begin
            sclk  <= 1'b1;
            rx_sh <= {rx_sh[DATA_W-2:0], miso};
          end
        end
        XFER: begin
          if (tick) begin
            if (sclk) begin
              sclk    <= 1'b0;
              bit_cnt <= bit_cnt + CNT_W'(1);
              // mosi stays on the last bit through HOLD.
              if (!last_fall) begin
                tx_sh <= tx_sh << 1;
                mosi  <= tx_sh[DATA_W-2];
              end
            end else begin
              sclk  <= 1'b1;
              rx_sh <= {rx_sh[DATA_W-2:0], miso};
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_L     <= 1'b1;
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
            mosi     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed plus randomized frames against two spi_master
// builds (CLK_DIV=4 and CLK_DIV=2). The slave model presents miso bits
// MSB first, starting at chip-select assertion and advancing after each
// sclk fall. Expected edge times come from the frame timing formulas.
module tb_spi_master;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_L = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tv4 = 1'b0, tv2 = 1'b0;
  logic          miso4 = 1'b0, miso2 = 1'b0;
  logic          rdy4, rxv4, sclk4, cs4, mosi4;
  logic          rdy2, rxv2, sclk2, cs2, mosi2;
  logic [DW-1:0] rxd4, rxd2;

  int npass = 0;
  int ntotal = 0;
  int gcyc = 0;

  always #5 clk = ~clk;

  spi_master #(.DATA_W(DW), .CLK_DIV(4)) u_div4 (
    .clk(clk), .rst_L(rst_L), .tx_data(tx_data), .tx_valid(tv4),
    .tx_ready(rdy4), .rx_data(rxd4), .rx_valid(rxv4), .sclk(sclk4),
    .cs_L(cs4), .mosi(mosi4), .miso(miso4)
  );

  spi_master #(.DATA_W(DW), .CLK_DIV(2)) u_div2 (
    .clk(clk), .rst_L(rst_L), .tx_data(tx_data), .tx_valid(tv2),
    .tx_ready(rdy2), .rx_data(rxd2), .rx_valid(rxv2), .sclk(sclk2),
    .cs_L(cs2), .mosi(mosi2), .miso(miso2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    gcyc++;
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) tv2 = v;
    else     tv4 = v;
  endtask

  task automatic observe(input bit sel, output logic cs, output logic sc,
                         output logic mo, output logic rv, output logic rd,
                         output logic [DW-1:0] rx);
    cs = sel ? cs2   : cs4;
    sc = sel ? sclk2 : sclk4;
    mo = sel ? mosi2 : mosi4;
    rv = sel ? rxv2  : rxv4;
    rd = sel ? rdy2  : rdy4;
    rx = sel ? rxd2  : rxd4;
  endtask

  task automatic idle_check(input bit sel, input int n, input logic [DW-1:0] exp_rx);
    logic cs, sc, mo, rv, rd;
    logic [DW-1:0] rx;
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      observe(sel, cs, sc, mo, rv, rd, rx);
      if (!(cs === 1'b1 && sc === 1'b0 && mo === 1'b0 && rv === 1'b0 &&
            rd === 1'b1 && rx === exp_rx)) bad++;
    end
    chk("idle_cycles_bad", bad, 0);
    chk("idle_rx_data", int'(rx), int'(exp_rx));
  endtask

  // Runs one frame on the selected DUT and checks it against the timing
  // formulas. disturb_at: frame cycle at which tx_data changes and tx_valid
  // pulses (-1 = never). rst_rise: sclk rise on which reset is asserted
  // (0 = never). keep: leave tx_valid high and present next_d for a
  // back-to-back frame.
  task automatic frame(input bit sel, input logic [DW-1:0] txd,
                       input logic [DW-1:0] pat, input bit keep,
                       input logic [DW-1:0] next_d, input int disturb_at,
                       input int rst_rise, output int fall_g, output int rise_g);
    int T;
    int cyc, rises, falls, nrxv, rxv_cyc, csr_cyc, rdy_cyc;
    int sclk_cs_high, rdy_early;
    logic cs, sc, mo, rv, rd, prev;
    logic [DW-1:0] rx;
    bit done;
    T = sel ? 2 : 4;
    cyc = -1; rises = 0; falls = 0; nrxv = 0;
    rxv_cyc = -1; csr_cyc = -1; rdy_cyc = -1;
    sclk_cs_high = 0; rdy_early = 0; prev = 1'b0; done = 1'b0;
    fall_g = -1; rise_g = -1;
    tx_data = txd;
    set_valid(sel, 1'b1);
    for (int n = 0; n < 600 && !done; n++) begin
      step();
      observe(sel, cs, sc, mo, rv, rd, rx);
      if (cyc < 0) begin
        if (cs === 1'b0) begin
          cyc = 0;
          fall_g = gcyc;
          miso4 = pat[DW-1];
          miso2 = pat[DW-1];
          if (!keep) set_valid(sel, 1'b0);
          tx_data = next_d;
        end
      end else begin
        cyc++;
      end
      if (cyc >= 0) begin
        if (sc && !prev) begin
          chk("rise_time", cyc, T * (2 * rises + 1));
          chk("mosi_at_rise", int'(mo), int'(txd[DW-1-rises]));
          rises++;
          if (rises == rst_rise) begin
            rst_L = 1'b0;
            #1;
            observe(sel, cs, sc, mo, rv, rd, rx);
            chk("rst_cs_L", int'(cs), 1);
            chk("rst_sclk", int'(sc), 0);
            chk("rst_rx_valid", int'(rv), 0);
            chk("rst_rx_data", int'(rx), 0);
            chk("rst_tx_ready", int'(rd), 1);
            step();
            step();
            rst_L = 1'b1;
            set_valid(sel, 1'b0);
            return;
          end
        end
        if (!sc && prev) begin
          chk("fall_time", cyc, T * (2 * falls + 2));
          falls++;
          if (falls < DW) begin
            miso4 = pat[DW-1-falls];
            miso2 = pat[DW-1-falls];
          end
        end
        if (sc && cs) sclk_cs_high++;
        if (rv) begin
          nrxv++;
          rxv_cyc = cyc;
          chk("rx_data", int'(rx), int'(pat));
        end
        if (cs && csr_cyc < 0) begin
          csr_cyc = cyc;
          rise_g = gcyc;
        end
        if (rd) begin
          if (cyc < (2 * DW + 2) * T) rdy_early++;
          rdy_cyc = cyc;
          done = 1'b1;
        end
        if (cyc == disturb_at) begin
          tx_data = ~txd;
          set_valid(sel, 1'b1);
        end
        if (disturb_at >= 0 && cyc == disturb_at + 1) set_valid(sel, 1'b0);
      end
      prev = sc;
    end
    chk("sclk_rises", rises, DW);
    chk("rx_valid_pulses", nrxv, 1);
    chk("rx_valid_time", rxv_cyc, (2 * DW + 1) * T);
    chk("cs_rise_time", csr_cyc, (2 * DW + 1) * T);
    chk("tx_ready_time", rdy_cyc, (2 * DW + 2) * T);
    chk("tx_ready_early", rdy_early, 0);
    chk("sclk_while_cs_high", sclk_cs_high, 0);
  endtask

  initial begin
    int fg, rg, fg2, rg2;
    logic [DW-1:0] d, p, p2;

    // Reset held: outputs at reset values.
    repeat (3) step();
    chk("reset_cs_L", int'(cs4), 1);
    chk("reset_sclk", int'(sclk4), 0);
    chk("reset_mosi", int'(mosi4), 0);
    chk("reset_tx_ready", int'(rdy4), 1);
    chk("reset_rx_valid", int'(rxv4), 0);
    chk("reset_rx_data", int'(rxd4), 0);
    rst_L = 1'b1;
    idle_check(0, 20, '0);

    // Basic frame: 0xA5 out, 0x3C in.
    frame(0, 8'hA5, 8'h3C, 0, 8'hA5, -1, 0, fg, rg);
    chk("a5_rx_held", int'(rxd4), 8'h3C);
    idle_check(0, 10, 8'h3C);

    // Back-to-back with tx_valid held.
    p = 8'($urandom);
    p2 = 8'($urandom);
    frame(0, 8'hFF, p, 1, 8'h00, -1, 0, fg, rg);
    frame(0, 8'h00, p2, 0, 8'h00, -1, 0, fg2, rg2);
    chk("b2b_cs_high_gap", fg2 - rg, 5);
    idle_check(0, 12, p2);

    // Request during an active frame is ignored.
    p = 8'($urandom);
    frame(0, 8'h96, p, 0, 8'h96, 20, 0, fg, rg);
    idle_check(0, 30, p);

    // Reset on the 4th sclk rise aborts the frame.
    p = 8'($urandom);
    frame(0, 8'($urandom), p, 0, 8'h00, -1, 4, fg, rg);
    idle_check(0, 80, '0);
    p = 8'($urandom);
    frame(0, 8'h5A, p, 0, 8'h5A, -1, 0, fg, rg);
    idle_check(0, 5, p);

    // CLK_DIV=2 build.
    p = 8'($urandom);
    frame(1, 8'h81, p, 0, 8'h81, -1, 0, fg, rg);
    idle_check(1, 5, p);

    // Randomized frames on both builds.
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      p = 8'($urandom);
      frame(i[0], d, p, 0, 8'($urandom), -1, 0, fg, rg);
      idle_check(i[0], int'($urandom_range(1, 6)), p);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
